// File: rtl/rf_wport_arb_if.sv
// Write-port bundle between the two writeback sources, the arbiter and the register file.
// The arbiter takes the slave side; the requesters/register file take the master side.
interface rf_wport_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              p_valid;
    logic              p_ready;
    logic              p_wen;
    logic [ADDR_W-1:0] p_waddr;
    logic [DATA_W-1:0] p_wdata;

    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_waddr;
    logic [DATA_W-1:0] m_wdata;

    logic              reg_wen;
    logic [ADDR_W-1:0] reg_waddr;
    logic [DATA_W-1:0] reg_wdata;
    logic [3:0]        starve_cnt;

    modport slave (
        input  p_valid, p_wen, p_waddr, p_wdata,
        input  m_valid, m_waddr, m_wdata,
        output p_ready, m_ready,
        output reg_wen, reg_waddr, reg_wdata, starve_cnt
    );

    modport master (
        output p_valid, p_wen, p_waddr, p_wdata,
        output m_valid, m_waddr, m_wdata,
        input  p_ready, m_ready,
        input  reg_wen, reg_waddr, reg_wdata, starve_cnt
    );
endinterface

// File: rtl/rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback normally wins, the multi-cycle
// unit is forced through after STARVE_MAX lost conflicts. One-cycle registered write out.
module rf_wport_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4
) (
    input logic            clk,
    input logic            rst_n,
    rf_wport_arb_if.slave  bus
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } wr_req_t;

    logic    conflict;
    logic    m_win;
    logic    p_acc;
    logic    m_acc;
    logic    p_win_conf;
    logic [3:0] cnt_q;
    wr_req_t wr_nxt;
    wr_req_t wr_q;

    // Only a pipeline request that really writes competes with the multi-cycle unit.
    always_comb begin
        conflict   = bus.p_valid & bus.p_wen & bus.m_valid;
        m_win      = conflict & (cnt_q == SMAX);
        p_win_conf = conflict & ~m_win;
        p_acc      = rst_n & bus.p_valid & ~m_win;
        m_acc      = rst_n & bus.m_valid & (~conflict | m_win);
    end

    // At most one of the two accepted requests carries write intent, so a priority mux suffices.
    always_comb begin
        wr_nxt = '0;
        if (m_acc) begin
            wr_nxt.wen   = (bus.m_waddr != '0);
            wr_nxt.waddr = bus.m_waddr;
            wr_nxt.wdata = bus.m_wdata;
        end else if (p_acc && bus.p_wen) begin
            wr_nxt.wen   = (bus.p_waddr != '0);
            wr_nxt.waddr = bus.p_waddr;
            wr_nxt.wdata = bus.p_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q.wen <= wr_nxt.wen;
            // Address/data hold across idle cycles so the RF sees a stable bus.
            if (wr_nxt.wen) begin
                wr_q.waddr <= wr_nxt.waddr;
                wr_q.wdata <= wr_nxt.wdata;
            end
            if (m_acc)
                cnt_q <= '0;
            else if (p_win_conf && cnt_q < SMAX)
                cnt_q <= cnt_q + 4'd1;
        end
    end

    assign bus.p_ready    = p_acc;
    assign bus.m_ready    = m_acc;
    assign bus.reg_wen    = wr_q.wen;
    assign bus.reg_waddr  = wr_q.waddr;
    assign bus.reg_wdata  = wr_q.wdata;
    assign bus.starve_cnt = cnt_q;
endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed and constrained-random checks for rf_wport_arb.
module tb_rf_wport_arb;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wport_arb_if #(.DATA_W(32), .ADDR_W(5)) bus();

    rf_wport_arb #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(SM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bus.p_valid = pv; bus.p_wen = pw; bus.p_waddr = pa; bus.p_wdata = pd;
        bus.m_valid = mv; bus.m_waddr = ma; bus.m_wdata = md;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, with valids high to show readies are gated
        drive(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2);
        #12;
        chk("rst_wen",   bus.reg_wen, 0);
        chk("rst_waddr", bus.reg_waddr, 0);
        chk("rst_wdata", bus.reg_wdata, 0);
        chk("rst_cnt",   bus.starve_cnt, 0);
        chk("rst_prdy",  bus.p_ready, 0);
        chk("rst_mrdy",  bus.m_ready, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("idle_wen", bus.reg_wen, 0);

        // lone pipeline write
        drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        #1;
        chk("p_alone_prdy", bus.p_ready, 1);
        chk("p_alone_mrdy", bus.m_ready, 0);
        tick;
        chk("p_alone_wen",   bus.reg_wen, 1);
        chk("p_alone_waddr", bus.reg_waddr, 5);
        chk("p_alone_wdata", bus.reg_wdata, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("idle2_wen",   bus.reg_wen, 0);
        chk("idle2_waddr", bus.reg_waddr, 5);

        // starvation: pipeline wins SM conflicts, then the multi-cycle unit is forced in
        for (int i = 0; i < SM; i++) begin
            drive(1, 1, 5'd1, 32'd100 + 32'(i), 1, 5'd7, 32'h12345678);
            #1;
            chk("starve_prdy", bus.p_ready, 1);
            chk("starve_mrdy", bus.m_ready, 0);
            tick;
            chk("starve_cnt",   bus.starve_cnt, 64'(i + 1));
            chk("starve_waddr", bus.reg_waddr, 1);
            chk("starve_wdata", bus.reg_wdata, 64'(100 + i));
        end
        drive(1, 1, 5'd1, 32'd200, 1, 5'd7, 32'h12345678);
        #1;
        chk("forced_prdy", bus.p_ready, 0);
        chk("forced_mrdy", bus.m_ready, 1);
        tick;
        chk("forced_wen",   bus.reg_wen, 1);
        chk("forced_waddr", bus.reg_waddr, 7);
        chk("forced_wdata", bus.reg_wdata, 32'h12345678);
        chk("forced_cnt",   bus.starve_cnt, 0);

        // non-conflicting joint acceptance
        drive(1, 0, 5'd4, 32'hAAAA, 1, 5'd3, 32'h5555);
        #1;
        chk("joint_prdy", bus.p_ready, 1);
        chk("joint_mrdy", bus.m_ready, 1);
        tick;
        chk("joint_wen",   bus.reg_wen, 1);
        chk("joint_waddr", bus.reg_waddr, 3);
        chk("joint_wdata", bus.reg_wdata, 32'h5555);
        chk("joint_cnt",   bus.starve_cnt, 0);

        // partial starvation cleared by a later uncontested accept
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5'd2, 32'h22, 1, 5'd8, 32'h88);
            tick;
        end
        chk("part_cnt", bus.starve_cnt, 2);
        drive(0, 0, 0, 0, 1, 5'd8, 32'h88);
        #1;
        chk("part_mrdy", bus.m_ready, 1);
        tick;
        chk("part_clr",   bus.starve_cnt, 0);
        chk("part_waddr", bus.reg_waddr, 8);

        // pipeline handshake without write intent
        drive(1, 0, 5'd6, 32'h66, 0, 0, 0);
        #1;
        chk("nowen_prdy", bus.p_ready, 1);
        tick;
        chk("nowen_wen", bus.reg_wen, 0);

        // x0 write is swallowed
        drive(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        #1;
        chk("x0_mrdy", bus.m_ready, 1);
        tick;
        chk("x0_wen",   bus.reg_wen, 0);
        chk("x0_waddr", bus.reg_waddr, 8);

        // reset between acceptance and the write edge
        drive(1, 1, 5'd9, 32'h99, 0, 0, 0);
        #1;
        chk("rstmid_prdy", bus.p_ready, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_wen",  bus.reg_wen, 0);
        chk("rstmid_cnt",  bus.starve_cnt, 0);
        chk("rstmid_prdy0", bus.p_ready, 0);
        tick;
        chk("rstmid_wen2",  bus.reg_wen, 0);
        chk("rstmid_waddr", bus.reg_waddr, 0);
        rst_n = 1'b1;
        drive(1, 1, 5'd10, 32'h1010, 0, 0, 0);
        tick;
        chk("post_wen",   bus.reg_wen, 1);
        chk("post_waddr", bus.reg_waddr, 10);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;

        // random traffic against a reference arbiter model
        begin
            logic        pv, pw, mv, conf, ep, em, ewen;
            logic [4:0]  pa, ma, eaddr;
            logic [31:0] pd, md, edata;
            int          cnt, wait_c;
            mv = 0; ma = 0; md = 0; cnt = 0; wait_c = 0;
            for (int c = 0; c < 3000; c++) begin
                if (!mv && $urandom_range(0, 2) == 0) begin
                    mv = 1; ma = 5'($urandom_range(0, 31)); md = $urandom; wait_c = 0;
                end
                pv = ($urandom_range(0, 3) != 0);
                pw = ($urandom_range(0, 3) != 0);
                pa = 5'($urandom_range(0, 31));
                pd = $urandom;
                drive(pv, pw, pa, pd, mv, ma, md);
                #1;
                conf = pv & pw & mv;
                if (conf) begin
                    em = (cnt == SM);
                    ep = !em;
                end else begin
                    em = mv;
                    ep = pv;
                end
                chk("rnd_prdy", bus.p_ready, ep);
                chk("rnd_mrdy", bus.m_ready, em);
                if (mv) wait_c++;
                ewen = 0; eaddr = 0; edata = 0;
                if (em) begin
                    ewen = (ma != 0); eaddr = ma; edata = md;
                    chk("rnd_mwait", 64'(wait_c <= SM + 1), 1);
                end else if (ep && pw) begin
                    ewen = (pa != 0); eaddr = pa; edata = pd;
                end
                if (em) cnt = 0;
                else if (conf) cnt++;
                tick;
                chk("rnd_wen", bus.reg_wen, ewen);
                if (ewen) begin
                    chk("rnd_waddr", bus.reg_waddr, eaddr);
                    chk("rnd_wdata", bus.reg_wdata, edata);
                end
                chk("rnd_cnt", bus.starve_cnt, 64'(cnt));
                if (em) mv = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
